// File: rtl/mem_copy_dma.sv
// Bus-initiator DMA that copies len words from src_addr to dst_addr, one read then one write per word.
// Optional MEM_COPY_FILL_EN adds a fill mode that writes fill_data to every destination word.
module mem_copy_dma #(
    parameter int AW = 9,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW-1:0] src_addr,
    input  logic [AW-1:0] dst_addr,
    input  logic [AW-1:0] len,
`ifdef MEM_COPY_FILL_EN
    input  logic          fill,
    input  logic [DW-1:0] fill_data,
`endif
    input  logic          bus_gnt,
    input  logic [DW-1:0] read_data,
    output logic          bus_req,
    output logic [1:0]    mem_cmd,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] write_data,
    output logic          busy,
    output logic          done
);

    localparam logic [1:0]    MNONE  = 2'b00;
    localparam logic [1:0]    MREAD  = 2'b01;
    localparam logic [1:0]    MWRITE = 2'b10;
    localparam logic [AW-1:0] ZERO_A = {AW{1'b0}};
    localparam logic [AW-1:0] ONE_A  = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [DW-1:0] ZERO_D = {DW{1'b0}};

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        RD   = 3'd2,
        CAP  = 3'd3,
        WR   = 3'd4,
        FIN  = 3'd5
    } state_t;

    state_t        state_r;
    logic [AW-1:0] src_r;
    logic [AW-1:0] dst_r;
    logic [AW-1:0] count_r;
    logic [DW-1:0] data_r;
    logic          zero_len_r;
`ifdef MEM_COPY_FILL_EN
    logic          fill_mode_r;
    logic [DW-1:0] fill_data_r;
`endif

    // Copy sequencer: state, address/count bookkeeping and all registered bus outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            src_r       <= ZERO_A;
            dst_r       <= ZERO_A;
            count_r     <= ZERO_A;
            data_r      <= ZERO_D;
            zero_len_r  <= 1'b0;
`ifdef MEM_COPY_FILL_EN
            fill_mode_r <= 1'b0;
            fill_data_r <= ZERO_D;
`endif
            bus_req     <= 1'b0;
            mem_cmd     <= MNONE;
            mem_addr    <= ZERO_A;
            write_data  <= ZERO_D;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            mem_cmd <= MNONE;
            done    <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (len != ZERO_A) begin
                            src_r       <= src_addr;
                            dst_r       <= dst_addr;
                            count_r     <= len;
                            zero_len_r  <= 1'b0;
`ifdef MEM_COPY_FILL_EN
                            fill_mode_r <= fill;
                            fill_data_r <= fill_data;
`endif
                            bus_req     <= 1'b1;
                            state_r     <= REQ;
                        end else begin
                            // Empty copy never touches the bus; done is deferred to keep 2-cycle latency.
                            zero_len_r <= 1'b1;
                            state_r    <= FIN;
                        end
                    end else begin
                        busy <= 1'b0;
                    end
                end
                REQ: begin
                    if (bus_gnt) begin
`ifdef MEM_COPY_FILL_EN
                        state_r <= fill_mode_r ? WR : RD;
`else
                        state_r <= RD;
`endif
                    end
                end
                RD: begin
                    if (bus_gnt) begin
                        mem_cmd  <= MREAD;
                        mem_addr <= src_r;
                        state_r  <= CAP;
                    end
                end
                CAP: begin
                    data_r  <= read_data;
                    state_r <= WR;
                end
                WR: begin
                    if (bus_gnt) begin
                        mem_cmd  <= MWRITE;
                        mem_addr <= dst_r;
`ifdef MEM_COPY_FILL_EN
                        write_data <= fill_mode_r ? fill_data_r : data_r;
`else
                        write_data <= data_r;
`endif
                        src_r    <= src_r + ONE_A;
                        dst_r    <= dst_r + ONE_A;
                        count_r  <= count_r - ONE_A;
                        if (count_r == ONE_A) begin
                            bus_req <= 1'b0;
                            done    <= 1'b1;
                            state_r <= FIN;
                        end else begin
`ifdef MEM_COPY_FILL_EN
                            state_r <= fill_mode_r ? WR : RD;
`else
                            state_r <= RD;
`endif
                        end
                    end
                end
                FIN: begin
                    done       <= zero_len_r;
                    zero_len_r <= 1'b0;
                    bus_req    <= 1'b0;
                    busy       <= 1'b0;
                    state_r    <= IDLE;
                end
                default: begin
                    bus_req <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule
